uart_rx_core: RTL

Serial receive engine of the UART, the counterpart on the far end of the `tx` line driven by `uart_tx`. It oversamples `rx` using the same 16x `baud_pulse` tick the baud generator gives the transmitter. It frames each character according to the LCR fields: 5-8 data bits, optional odd, even or stick parity. Each received character, with its error flags, is handed to the RX FIFO as a single-cycle push.

---
 rtl/uart_rx_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start/data/parity/stop framing driven by baud_pulse,
// one push per character with parity, framing and break flags.
module uart_rx_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic       push,
  output logic [7:0] rx_data,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_MARK
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  wls_q, wls_d;
  logic        pen_q, pen_d, eps_q, eps_d, sp_q, sp_d;
  logic        par_bit_q, par_bit_d, perr_q, perr_d;
  logic        push_q, push_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
  logic        exp_par;
  logic        last_bit;

  // Synchronizer resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign exp_par  = sp_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);
  assign last_bit = (bcnt_q == ({1'b0, wls_q} + 3'd4));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    sp_d      = sp_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    push_d    = 1'b0;
    rx_data_d = rx_data_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    bi_d      = bi_q;
    if (baud_pulse) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = 4'd0;
            wls_d   = wls;
            pen_d   = pen;
            eps_d   = eps;
            sp_d    = sp;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d   = S_DATA;
              cnt_d     = 4'd0;
              bcnt_d    = 3'd0;
              data_d    = 8'h00;
              par_bit_d = 1'b0;
              perr_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            cnt_d          = 4'd0;
            data_d[bcnt_q] = rx_s_q;
            bcnt_d         = bcnt_q + 3'd1;
            if (last_bit) state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_PARITY: begin
          if (cnt_q == 4'd15) begin
            cnt_d     = 4'd0;
            par_bit_d = rx_s_q;
            perr_d    = (rx_s_q != exp_par);
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'd15) begin
            cnt_d     = 4'd0;
            push_d    = 1'b1;
            rx_data_d = data_q;
            pe_d      = perr_q;
            fe_d      = ~rx_s_q;
            bi_d      = (data_q == 8'h00) && !par_bit_q && !rx_s_q;
            state_d   = rx_s_q ? S_IDLE : S_MARK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_MARK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      bcnt_q    <= 3'd0;
      data_q    <= 8'h00;
      wls_q     <= 2'd0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      sp_q      <= 1'b0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      push_q    <= 1'b0;
      rx_data_q <= 8'h00;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      data_q    <= data_d;
      wls_q     <= wls_d;
      pen_q     <= pen_d;
      eps_q     <= eps_d;
      sp_q      <= sp_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      push_q    <= push_d;
      rx_data_q <= rx_data_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      bi_q      <= bi_d;
    end
  end

  assign push    = push_q;
  assign rx_data = rx_data_q;
  assign pe      = pe_q;
  assign fe      = fe_q;
  assign bi      = bi_q;
  assign busy    = (state_q != S_IDLE);

endmodule
